// File: rtl/mips_multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS control unit. This covers opcode and
// funct fields, ALU operation codes, datapath mux selects, the FSM state
// encoding, and a helper that maps a state to its datapath strobe set.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_SEXT    = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_JUMP   = 2'b01;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_ITWB   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_write;
    logic       mem_read;
    logic       ir_write;
    logic       reg_dst;
    logic       write_reg_sel;
    logic       mem_to_reg;
    logic       write_data_sel;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_operation;
  } ctrl_t;

  // Strobe set for a state; EXEC and IEXEC take their ALU op from the decoded IR
  function automatic ctrl_t ctrl_for_state(state_t s, logic [2:0] exec_op,
                                           logic [2:0] imm_op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
        c.alu_src_b = SRCB_FOUR; c.alu_operation = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_SEXT_SH; c.alu_operation = ALU_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_SEXT; c.alu_operation = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1; c.ior_d = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1; c.ior_d = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_B; c.alu_operation = exec_op;
      end
      S_RTWB: begin
        c.reg_dst = 1'b1; c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_B; c.alu_operation = ALU_SUB;
        c.pc_write_cond = 1'b1; c.pc_src = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write = 1'b1; c.pc_src = PCSRC_JUMP;
      end
      S_IEXEC: begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_SEXT; c.alu_operation = imm_op;
      end
      S_ITWB: begin
        c.reg_write = 1'b1;
      end
      S_JAL: begin
        c.pc_write = 1'b1; c.pc_src = PCSRC_JUMP; c.reg_write = 1'b1;
        c.write_reg_sel = 1'b1; c.write_data_sel = 1'b1;
      end
      S_JR: begin
        c.pc_write = 1'b1; c.pc_src = PCSRC_REGA;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// Controller <-> datapath bundle. The instruction register and the zero flag
// flow in; every strobe plus the debug state flows out.
interface mips_multicycle_controller_if #(parameter int STATE_W = 4);
  logic [31:0]        Instruction;
  logic               ZeroFlag;
  logic               PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite;
  logic               RegDst, WriteRegSel, MemtoReg, WriteDataSel, RegWrite, ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSrc;
  logic [2:0]         ALUoperation;
  logic               IllegalOp;
  logic [STATE_W-1:0] StateOut;

  modport master (
    input  Instruction, ZeroFlag,
    output PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite,
           RegDst, WriteRegSel, MemtoReg, WriteDataSel, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, ALUoperation, IllegalOp, StateOut
  );

  modport slave (
    output Instruction, ZeroFlag,
    input  PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite,
           RegDst, WriteRegSel, MemtoReg, WriteDataSel, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, ALUoperation, IllegalOp, StateOut
  );
endinterface

// File: rtl/mips_multicycle_controller_alu_decoder.sv
// R-type funct field to ALU operation. funct_valid is low for any funct the
// controller does not execute, so the FSM can flag it as illegal.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_operation,
  output logic       funct_valid
);

  // Map supported functs to ALU codes and fall back to ADD for anything else
  always_comb begin
    alu_operation = ALU_ADD;
    funct_valid   = 1'b1;
    case (funct)
      FN_ADD:  alu_operation = ALU_ADD;
      FN_SUB:  alu_operation = ALU_SUB;
      FN_AND:  alu_operation = ALU_AND;
      FN_OR:   alu_operation = ALU_OR;
      FN_SLT:  alu_operation = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath. The strobes are
// registered as the state is entered, and all outputs are gated to zero while
// reset is held low.
module mips_multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W   = 4,
  parameter int ENABLE_JR = 1
) (
  input logic                          clk,
  input logic                          rst,
  mips_multicycle_controller_if.master bus
);

  state_t     state, next_state;
  ctrl_t      ctrl_q;
  logic [5:0] opcode, funct;
  logic [2:0] exec_op, imm_op;
  logic       funct_valid, is_jr, decode_illegal;
  logic       unused_inputs;

  assign opcode = bus.Instruction[31:26];
  assign funct  = bus.Instruction[5:0];
  assign is_jr  = (opcode == OP_RTYPE) && (funct == FN_JR) && (ENABLE_JR != 0);
  assign imm_op = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;

  // The branch decision belongs to the datapath, so the zero flag is deliberately ignored
  assign unused_inputs = ^{bus.ZeroFlag, bus.Instruction[25:6]};

  mips_alu_decoder u_alu_decoder (
    .funct         (funct),
    .alu_operation (exec_op),
    .funct_valid   (funct_valid)
  );

  // Next-state selection; illegal instructions are detected only in DECODE and return to FETCH
  always_comb begin
    next_state     = S_FETCH;
    decode_illegal = 1'b0;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (is_jr)            next_state = S_JR;
            else if (funct_valid) next_state = S_EXEC;
            else                  decode_illegal = 1'b1;
          end
          OP_LW, OP_SW:     next_state = S_MEMADR;
          OP_BEQ:           next_state = S_BRANCH;
          OP_ADDI, OP_SLTI: next_state = S_IEXEC;
          OP_J:             next_state = S_JUMP;
          OP_JAL:           next_state = S_JAL;
          default:          decode_illegal = 1'b1;
        endcase
      end
      S_MEMADR: next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  next_state = S_MEMWB;
      S_EXEC:   next_state = S_RTWB;
      S_IEXEC:  next_state = S_ITWB;
      default:  next_state = S_FETCH;
    endcase
  end

  // State register plus registered strobes for the state being entered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_FETCH;
      ctrl_q <= ctrl_for_state(S_FETCH, exec_op, imm_op);
    end else begin
      state  <= next_state;
      ctrl_q <= ctrl_for_state(next_state, exec_op, imm_op);
    end
  end

  assign bus.PCWrite      = rst & ctrl_q.pc_write;
  assign bus.PCWriteCond  = rst & ctrl_q.pc_write_cond;
  assign bus.IorD         = rst & ctrl_q.ior_d;
  assign bus.MemWrite     = rst & ctrl_q.mem_write;
  assign bus.MemRead      = rst & ctrl_q.mem_read;
  assign bus.IRWrite      = rst & ctrl_q.ir_write;
  assign bus.RegDst       = rst & ctrl_q.reg_dst;
  assign bus.WriteRegSel  = rst & ctrl_q.write_reg_sel;
  assign bus.MemtoReg     = rst & ctrl_q.mem_to_reg;
  assign bus.WriteDataSel = rst & ctrl_q.write_data_sel;
  assign bus.RegWrite     = rst & ctrl_q.reg_write;
  assign bus.ALUSrcA      = rst & ctrl_q.alu_src_a;
  assign bus.ALUSrcB      = rst ? ctrl_q.alu_src_b     : 2'b00;
  assign bus.PCSrc        = rst ? ctrl_q.pc_src        : 2'b00;
  assign bus.ALUoperation = rst ? ctrl_q.alu_operation : 3'b000;
  assign bus.IllegalOp    = rst & decode_illegal;
  assign bus.StateOut     = rst ? STATE_W'(state) : '0;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Self-checking bench for the multicycle MIPS controller. Two controllers are
// instantiated, one with jr decoding enabled and one with it disabled. Each
// one runs its own directed-then-random instruction stream. The bench model
// derives the state sequence and the strobes from the instruction class.
module tb_mips_multicycle_controller;

  localparam int K_ILL = 0, K_R = 1, K_LW = 2, K_SW = 3, K_BEQ = 4;
  localparam int K_J = 5, K_JAL = 6, K_JR = 7, K_ADDI = 8, K_SLTI = 9;

  typedef struct packed {
    logic       pc_write, pc_write_cond, ior_d, mem_write, mem_read, ir_write;
    logic       reg_dst, write_reg_sel, mem_to_reg, write_data_sel, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       illegal;
    logic [3:0] state_out;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mips_multicycle_controller_if #(.STATE_W(4)) bus_a ();
  mips_multicycle_controller_if #(.STATE_W(4)) bus_b ();

  mips_multicycle_controller #(.STATE_W(4), .ENABLE_JR(1)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  mips_multicycle_controller #(.STATE_W(4), .ENABLE_JR(0)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  // Instruction classification straight from the opcode / funct tables
  function automatic int classify(input logic [31:0] instr, input bit en_jr);
    logic [5:0] op, fn;
    op = instr[31:26];
    fn = instr[5:0];
    case (op)
      6'b000000: begin
        if (fn == 6'b001000) return en_jr ? K_JR : K_ILL;
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)
          return K_R;
        return K_ILL;
      end
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b001000: return K_ADDI;
      6'b001010: return K_SLTI;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  // Expected strobes for one step of an instruction, from the per-state table
  function automatic obs_t expect_obs(input int st, input int kind, input logic [31:0] instr);
    obs_t o;
    o = '0;
    o.state_out = st[3:0];
    case (st)
      0:  begin o.pc_write = 1; o.mem_read = 1; o.ir_write = 1; o.alu_src_b = 2'b01; o.alu_op = 3'b010; end
      1:  begin o.alu_src_b = 2'b11; o.alu_op = 3'b010; o.illegal = (kind == K_ILL); end
      2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 3'b010; end
      3:  begin o.mem_read = 1; o.ior_d = 1; end
      4:  begin o.mem_to_reg = 1; o.reg_write = 1; end
      5:  begin o.mem_write = 1; o.ior_d = 1; end
      6:  begin
            o.alu_src_a = 1;
            case (instr[5:0])
              6'h20:   o.alu_op = 3'b010;
              6'h22:   o.alu_op = 3'b110;
              6'h24:   o.alu_op = 3'b000;
              6'h25:   o.alu_op = 3'b001;
              default: o.alu_op = 3'b111;
            endcase
          end
      7:  begin o.reg_dst = 1; o.reg_write = 1; end
      8:  begin o.alu_src_a = 1; o.alu_op = 3'b110; o.pc_write_cond = 1; o.pc_src = 2'b10; end
      9:  begin o.pc_write = 1; o.pc_src = 2'b01; end
      10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = (kind == K_SLTI) ? 3'b111 : 3'b010; end
      11: begin o.reg_write = 1; end
      12: begin o.pc_write = 1; o.pc_src = 2'b01; o.reg_write = 1; o.write_reg_sel = 1; o.write_data_sel = 1; end
      13: begin o.pc_write = 1; o.pc_src = 2'b11; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic obs_t sample(input int which);
    obs_t o;
    if (which == 0)
      o = {bus_a.PCWrite, bus_a.PCWriteCond, bus_a.IorD, bus_a.MemWrite, bus_a.MemRead, bus_a.IRWrite,
           bus_a.RegDst, bus_a.WriteRegSel, bus_a.MemtoReg, bus_a.WriteDataSel, bus_a.RegWrite,
           bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.PCSrc, bus_a.ALUoperation, bus_a.IllegalOp, bus_a.StateOut};
    else
      o = {bus_b.PCWrite, bus_b.PCWriteCond, bus_b.IorD, bus_b.MemWrite, bus_b.MemRead, bus_b.IRWrite,
           bus_b.RegDst, bus_b.WriteRegSel, bus_b.MemtoReg, bus_b.WriteDataSel, bus_b.RegWrite,
           bus_b.ALUSrcA, bus_b.ALUSrcB, bus_b.PCSrc, bus_b.ALUoperation, bus_b.IllegalOp, bus_b.StateOut};
    return o;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int pick;
    r = $urandom;
    pick = $urandom_range(0, 11);
    case (pick)
      0, 1: begin
        r[31:26] = 6'b000000;
        case ($urandom_range(0, 4))
          0:       r[5:0] = 6'h20;
          1:       r[5:0] = 6'h22;
          2:       r[5:0] = 6'h24;
          3:       r[5:0] = 6'h25;
          default: r[5:0] = 6'h2A;
        endcase
      end
      2:  r[31:26] = 6'b100011;
      3:  r[31:26] = 6'b101011;
      4:  r[31:26] = 6'b000100;
      5:  r[31:26] = 6'b000010;
      6:  r[31:26] = 6'b000011;
      7:  begin r[31:26] = 6'b000000; r[5:0] = 6'b001000; end
      8:  r[31:26] = 6'b001000;
      9:  r[31:26] = 6'b001010;
      10: r = r;
      default: r[31:26] = 6'b000000;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int which, input logic [31:0] instr, input logic zf);
    if (which == 0) begin bus_a.Instruction = instr; bus_a.ZeroFlag = zf; end
    else            begin bus_b.Instruction = instr; bus_b.ZeroFlag = zf; end
  endtask

  // Runs one instruction starting in FETCH (#1 after the edge) and checks every step
  task automatic runInstr(input int which, input logic [31:0] instr, input int zf_mode);
    int kind;
    int seq[5];
    int len;
    logic zf;
    kind = classify(instr, which == 0);
    seq[0] = 0; seq[1] = 1; seq[2] = 0; seq[3] = 0; seq[4] = 0;
    case (kind)
      K_R:           begin len = 4; seq[2] = 6;  seq[3] = 7;  end
      K_LW:          begin len = 5; seq[2] = 2;  seq[3] = 3;  seq[4] = 4; end
      K_SW:          begin len = 4; seq[2] = 2;  seq[3] = 5;  end
      K_BEQ:         begin len = 3; seq[2] = 8;  end
      K_J:           begin len = 3; seq[2] = 9;  end
      K_JAL:         begin len = 3; seq[2] = 12; end
      K_JR:          begin len = 3; seq[2] = 13; end
      K_ADDI, K_SLTI: begin len = 4; seq[2] = 10; seq[3] = 11; end
      default:       len = 2;
    endcase
    for (int i = 0; i < len; i++) begin
      zf = (zf_mode == 2) ? logic'($urandom_range(0, 1)) : logic'(zf_mode);
      applyStimulus(which, instr, zf);
      @(negedge clk);
      checkOutput($sformatf("dut%0d instr %h step %0d", which, instr, i),
                  sample(which), expect_obs(seq[i], kind, instr));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runProgram(input int which);
    logic [31:0] directed [14];
    directed = '{32'h00221820, 32'h00221822, 32'h00221824, 32'h00221825, 32'h0022182A,
                 32'h8C220008, 32'hAC220008, 32'h08000010, 32'h0C000010, 32'h03E00008,
                 32'hFC000000, 32'h00000000, 32'h20220005, 32'h28220005};
    foreach (directed[i]) runInstr(which, directed[i], 2);
    runInstr(which, 32'h10220003, 0);
    runInstr(which, 32'h10220003, 1);
    for (int i = 0; i < 60; i++) runInstr(which, rand_instr(), 2);
  endtask

  task automatic doReset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    obs_t fetch_lit, exec_lit;
    fetch_lit = '0;
    fetch_lit.pc_write = 1; fetch_lit.mem_read = 1; fetch_lit.ir_write = 1;
    fetch_lit.alu_src_b = 2'b01; fetch_lit.alu_op = 3'b010;
    exec_lit = '0;
    exec_lit.alu_src_a = 1; exec_lit.alu_op = 3'b010; exec_lit.state_out = 4'd6;

    applyStimulus(0, 32'hFC000000, 1'b1);
    applyStimulus(1, 32'hFC000000, 1'b1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset outputs dut0", sample(0), '0);
    checkOutput("reset outputs dut1", sample(1), '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("fetch after reset dut0", sample(0), fetch_lit);
    checkOutput("fetch after reset dut1", sample(1), fetch_lit);
    doReset();

    fork
      runProgram(0);
      runProgram(1);
    join

    // Abort an add in EXEC with reset and check the clean restart
    doReset();
    applyStimulus(0, 32'h00221820, 1'b0);
    applyStimulus(1, 32'h00221820, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    checkOutput("exec add dut0", sample(0), exec_lit);
    checkOutput("exec add dut1", sample(1), exec_lit);
    rst = 1'b0;
    #1;
    checkOutput("reset in exec dut0", sample(0), '0);
    checkOutput("reset in exec dut1", sample(1), '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("fetch after abort dut0", sample(0), fetch_lit);
    checkOutput("fetch after abort dut1", sample(1), fetch_lit);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
